pwm_duty_meter: RTL
===================

# pwm_duty_meter

Measures an incoming PWM waveform and reports its high time, period and 8-bit duty value to the NIOS software layer. It is the feedback side of the DC-motor speed path: it decodes a PWM signal such as the motor-driver enable back into the same 0–255 duty scale that software writes as a speed setting. It is also used to check the speed generator in loopback and to read external PWM sources.

## Interface
Parameters:
- CNT_W, 16: width of the period and high-time counters.
- TIMEOUT, 65535: number of cycles without an edge before the input is declared stalled. Must be ≤ 2^CNT_W−1.

Ports:
- clk  input  1  system clock
- reset_b  input  1  asynchronous, active-low reset
- pwm_in  input  1  PWM input, asynchronous to clk
- clear_flags  input  1  synchronous; clears `overrun` when high for one cycle
- high_count  output  CNT_W  high time of the last complete period, in clk cycles
- period_count  output  CNT_W  last complete period (rising edge to rising edge), in clk cycles
- duty  output  8  floor(high_count·256/period_count), saturated to 255
- sample_valid  output  1  one-cycle pulse when the outputs update
- stalled  output  1  no edge for TIMEOUT cycles
- stuck_level  output  1  synchronized level of pwm_in when `stalled` was set
- overrun  output  1  sticky; a measurement was dropped because the divider was busy

## Operation
- **Input path:** a 2-flop synchronizer, then an edge-detect register. Detected rise/fall are one-cycle internal strobes.
- **Measurement FSM states:**
  - ARM: reset state. Waits for the first rise, which clears the counter and moves to HIGH. No sample is produced.
  - HIGH: on a fall, latch the counter as the high time and move to LOW.
  - LOW: on a rise, latch the period and start the divider. The counter restarts and the FSM returns to HIGH.
- **Counter:** counts cycles since the last rise and saturates at TIMEOUT.
- **Period definition:** period = cycles between consecutive detected rises. Minimum legal period is 2.
- **Divider:** restoring divider, one quotient bit per cycle, 9 cycles (quotient range 0..256).
  - Dividend is {high, 8'b0}; divisor is the period.
  - A quotient of 256 gives duty=255.
  - When the divider completes, `high_count`, `period_count` and `duty` update together and `sample_valid` pulses.
- **Overrun:** if a rise completes a period while the divider is busy, that period is discarded. `overrun` is set and the FSM continues measuring normally.
- **Stall:** in any state, if the counter reaches TIMEOUT:
  - `stalled` is set and `stuck_level` takes the current synchronized level.
  - `duty` becomes 255 if the level is 1, otherwise 0.
  - `high_count` and `period_count` hold their values.
  - `sample_valid` pulses once and the FSM returns to ARM.
  - `stalled` clears with the next normal `sample_valid`.
- **Simultaneous stall and divider completion:** the divider result is published first; the stall is published on the next cycle.
- **clear_flags with a new overrun in the same cycle:** the set wins.
- **Mid-operation reset:** an asynchronous reset during any state or division abandons it. No `sample_valid` is issued.
- **Reset values:** `high_count`=0, `period_count`=0, `duty`=0, `sample_valid`=0, `stalled`=0, `stuck_level`=0, `overrun`=0. FSM in ARM, divider idle.

## Timing
- The rise that closes a period is first sampled at clk edge 0. The detect strobe is active in cycle 3.
- The divider runs in cycles 4–12. `sample_valid` is high in cycle 13, with all result outputs valid in that same cycle.
- Outputs hold until the next `sample_valid`.
- Minimum period without overrun: 10 cycles.
- The stall pulse follows TIMEOUT cycles after the last detected edge, with no divider latency.

## Configuration
- **PWM_METER_FILTER_EN defined:**
  - A glitch filter follows the synchronizer. The filtered level changes only after 3 consecutive identical synchronized samples.
  - All latencies grow by 2 cycles.
  - Pulses of 2 cycles or fewer are ignored.
- **Undefined:** synchronizer only; every synchronized transition counts as an edge.

## Test plan
- **Loopback, set_speed=127:** drive pwm_in from an 8-bit free-running speed generator (output high while counter ≤ set_speed; 256-cycle period, high time set_speed+1). Required response: after the second rising edge, `high_count`=128, `period_count`=256, `duty`=128, `sample_valid` one pulse per period.
- **Loopback, set_speed=0:** `high_count`=1, `period_count`=256, `duty`=1.
- **Loopback, set_speed=255 (constant high):** after TIMEOUT=1000 cycles, `stalled`=1, `stuck_level`=1, `duty`=255, exactly one `sample_valid`. Changing to set_speed=63 then gives `stalled`=0 and `duty`=64.
- **Overrun:** a 6-cycle period with 3 cycles high sets `overrun`, and results come only from non-overlapping periods. `clear_flags` clears `overrun`; asserting it in the same cycle as a new overrun leaves `overrun`=1.
- **Reset:** asserting reset_b low during cycle 6 of a division leaves all outputs at reset values with no `sample_valid`. The first sample after release needs two rising edges.
- **Glitch filter (PWM_METER_FILTER_EN defined):** a 1-cycle high glitch inside a low phase is ignored and the measurement matches the clean waveform. With the macro undefined, the same glitch ends the period early.

Source files
------------

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and period of pwm_in and reports an 8-bit duty (0..255).
// Define PWM_METER_FILTER_EN to insert a 3-sample glitch filter after the synchronizer.
module pwm_duty_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             pwm_in,
    input  logic             clear_flags,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] period_count,
    output logic [7:0]       duty,
    output logic             sample_valid,
    output logic             stalled,
    output logic             stuck_level,
    output logic             overrun
);
    typedef enum logic [1:0] {ST_ARM = 2'd0, ST_HIGH = 2'd1, ST_LOW = 2'd2} state_t;

    localparam logic [CNT_W-1:0] TO_V    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_r, sync2_r, lvl_r, prev_r, rise_r, fall_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r, high_lat_r, div_high_r, div_per_r;
    logic             busy_r, stall_pend_r, pend_lvl_r;
    logic [3:0]       div_cnt_r;
    logic [CNT_W:0]   div_rem_r, sh_s, nrem_s;
    logic [8:0]       div_q_r, q_nxt_s;
    logic             ge_s, div_done_s, stall_hit_s, stall_evt_s, evt_lvl_s;
    logic             period_end_s, start_div_s, overrun_set_s;

    // Two-flop synchronizer for the asynchronous PWM input
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PWM_METER_FILTER_EN
    logic [1:0] hist_r;

    // Glitch filter: level follows the input only after three identical samples
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            hist_r <= 2'b00;
            lvl_r  <= 1'b0;
        end else begin
            hist_r <= {hist_r[0], sync2_r};
            if ((sync2_r == hist_r[0]) && (hist_r[0] == hist_r[1])) begin
                lvl_r <= sync2_r;
            end
        end
    end
`else
    // Level register fed directly by the synchronizer
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            lvl_r <= 1'b0;
        end else begin
            lvl_r <= sync2_r;
        end
    end
`endif

    // Edge detector producing registered one-cycle rise/fall strobes
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            prev_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            prev_r <= lvl_r;
            rise_r <= lvl_r & ~prev_r;
            fall_r <= ~lvl_r & prev_r;
        end
    end

    // Divider step, event decoding; the first step compares without shifting (quotient bit 8)
    always_comb begin
        sh_s          = (div_cnt_r == 4'd9) ? div_rem_r : {div_rem_r[CNT_W-1:0], 1'b0};
        ge_s          = (sh_s >= {1'b0, div_per_r});
        nrem_s        = ge_s ? (sh_s - {1'b0, div_per_r}) : sh_s;
        q_nxt_s       = {div_q_r[7:0], ge_s};
        div_done_s    = busy_r && (div_cnt_r == 4'd1);
        stall_hit_s   = (cnt_r == TO_M1) && !rise_r;
        stall_evt_s   = stall_hit_s || stall_pend_r;
        evt_lvl_s     = stall_hit_s ? lvl_r : pend_lvl_r;
        period_end_s  = (state_r == ST_LOW) && rise_r;
        start_div_s   = period_end_s && !busy_r;
        overrun_set_s = period_end_s && busy_r;
    end

    // Measurement FSM and saturating cycles-since-rise counter
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r    <= ST_ARM;
            cnt_r      <= '0;
            high_lat_r <= '0;
        end else begin
            if (rise_r) begin
                cnt_r <= CNT_ONE;
            end else if (cnt_r != TO_V) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (stall_hit_s) begin
                state_r <= ST_ARM;
            end else begin
                case (state_r)
                    ST_ARM:  if (rise_r) state_r <= ST_HIGH;
                    ST_HIGH: if (fall_r) begin
                        high_lat_r <= cnt_r;
                        state_r    <= ST_LOW;
                    end
                    ST_LOW:  if (rise_r) state_r <= ST_HIGH;
                    default: state_r <= ST_ARM;
                endcase
            end
        end
    end

    // Restoring divider: {high, 8'b0} / period, one quotient bit per cycle
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            busy_r     <= 1'b0;
            div_cnt_r  <= 4'd0;
            div_rem_r  <= '0;
            div_q_r    <= 9'd0;
            div_high_r <= '0;
            div_per_r  <= '0;
        end else if (start_div_s) begin
            busy_r     <= 1'b1;
            div_cnt_r  <= 4'd9;
            div_rem_r  <= {1'b0, high_lat_r};
            div_q_r    <= 9'd0;
            div_high_r <= high_lat_r;
            div_per_r  <= cnt_r;
        end else if (busy_r) begin
            div_rem_r <= nrem_s;
            div_q_r   <= q_nxt_s;
            div_cnt_r <= div_cnt_r - 4'd1;
            if (div_cnt_r == 4'd1) begin
                busy_r <= 1'b0;
            end
        end
    end

    // Result publication; a stall coinciding with a finished division is deferred one cycle
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            high_count   <= '0;
            period_count <= '0;
            duty         <= 8'd0;
            sample_valid <= 1'b0;
            stalled      <= 1'b0;
            stuck_level  <= 1'b0;
            overrun      <= 1'b0;
            stall_pend_r <= 1'b0;
            pend_lvl_r   <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (div_done_s) begin
                high_count   <= div_high_r;
                period_count <= div_per_r;
                duty         <= q_nxt_s[8] ? 8'hFF : q_nxt_s[7:0];
                sample_valid <= 1'b1;
                stalled      <= 1'b0;
                stall_pend_r <= stall_evt_s;
                pend_lvl_r   <= evt_lvl_s;
            end else if (stall_evt_s) begin
                stalled      <= 1'b1;
                stuck_level  <= evt_lvl_s;
                duty         <= evt_lvl_s ? 8'hFF : 8'h00;
                sample_valid <= 1'b1;
                stall_pend_r <= 1'b0;
            end
            if (overrun_set_s) begin
                overrun <= 1'b1;
            end else if (clear_flags) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule
